// File: rtl/wb_pkg.sv
// Shared constants and slot type for the MEM->WB pipeline boundary.
package wb_pkg;

   localparam int unsigned WB_DATA_W = 32;
   localparam int unsigned WB_ADDR_W = 5;

   localparam logic [WB_ADDR_W-1:0] NOP_REG_ADDR = '0;
   localparam logic [WB_DATA_W-1:0] ZERO_WORD    = '0;

   localparam logic WRITE_EN  = 1'b1;
   localparam logic WRITE_DIS = 1'b0;
   localparam logic RST_EN    = 1'b1;

   typedef struct packed {
      logic                 we;
      logic [WB_ADDR_W-1:0] waddr;
      logic [WB_DATA_W-1:0] wdata;
   } wb_slot_t;

endpackage

// File: rtl/wb_if.sv
// Handshake/bus bundle between MEM stage, wb_pipe_stage and the register file.
// Optional HI/LO channel present when WB_HILO_EN is defined.
interface wb_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NCH    = 1,
   parameter int unsigned BCNT_W = 16
);
   logic                  stall_up;
   logic                  stall_here;
   logic                  flush;
   logic [NCH-1:0]        in_we;
   logic [NCH*ADDR_W-1:0] in_waddr;
   logic [NCH*DATA_W-1:0] in_wdata;
   logic [NCH-1:0]        out_we;
   logic [NCH*ADDR_W-1:0] out_waddr;
   logic [NCH*DATA_W-1:0] out_wdata;
   logic [BCNT_W-1:0]     bubble_cnt;
`ifdef WB_HILO_EN
   logic                  in_whilo;
   logic [DATA_W-1:0]     in_hi;
   logic [DATA_W-1:0]     in_lo;
   logic                  out_whilo;
   logic [DATA_W-1:0]     out_hi;
   logic [DATA_W-1:0]     out_lo;

   modport master (
      output stall_up, stall_here, flush, in_we, in_waddr, in_wdata,
             in_whilo, in_hi, in_lo,
      input  out_we, out_waddr, out_wdata, bubble_cnt,
             out_whilo, out_hi, out_lo
   );
   modport slave (
      input  stall_up, stall_here, flush, in_we, in_waddr, in_wdata,
             in_whilo, in_hi, in_lo,
      output out_we, out_waddr, out_wdata, bubble_cnt,
             out_whilo, out_hi, out_lo
   );
`else
   modport master (
      output stall_up, stall_here, flush, in_we, in_waddr, in_wdata,
      input  out_we, out_waddr, out_wdata, bubble_cnt
   );
   modport slave (
      input  stall_up, stall_here, flush, in_we, in_waddr, in_wdata,
      output out_we, out_waddr, out_wdata, bubble_cnt
   );
`endif
endinterface

// File: rtl/wb_pipe_slot.sv
// One stage register for one write channel: clear beats hold beats load.
module wb_pipe_slot #(
   parameter int unsigned W = 38
) (
   input  logic         clk,
   input  logic         load,
   input  logic         hold,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clear)
         q <= '0;
      else if (load && !hold)
         q <= d;
   end

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB boundary: NCH write channels through DEPTH stages with stall, bubble,
// flush, same-beat conflict resolution and saturating bubble counter. Optional WB_HILO_EN.
module wb_pipe_stage
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NCH    = 1,
   parameter int unsigned DEPTH  = 1,
   parameter int unsigned BCNT_W = 16
) (
   input logic clk,
   input logic rst,
   wb_if.slave bus
);

   localparam int unsigned SW = 1 + ADDR_W + DATA_W;

   logic              clr_all;
   logic              bubble;
   logic              clr_s0;
   logic              adv;
   logic [NCH-1:0]    we_res;
   logic [BCNT_W-1:0] bcnt;
   logic [SW-1:0]     slot_q [DEPTH][NCH];

   assign clr_all = (rst == RST_EN) || bus.flush;
   assign adv     = !bus.stall_here;
   assign bubble  = bus.stall_up && !bus.stall_here;
   // A bubble is stage 0 being cleared while the rest of the pipe advances.
   assign clr_s0  = clr_all || bubble;

   always_comb begin
      we_res = bus.in_we;
      for (int unsigned i = 0; i < NCH; i++) begin
         for (int unsigned j = i + 1; j < NCH; j++) begin
            if (bus.in_we[i] && bus.in_we[j] &&
                bus.in_waddr[i*ADDR_W +: ADDR_W] == bus.in_waddr[j*ADDR_W +: ADDR_W])
               we_res[i] = WRITE_DIS;
         end
      end
   end

   for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      for (genvar c = 0; c < NCH; c++) begin : g_ch
         if (s == 0) begin : g_first
            wb_pipe_slot #(.W(SW)) u_slot (
               .clk   (clk),
               .load  (adv),
               .hold  (bus.stall_here),
               .clear (clr_s0),
               .d     ({we_res[c], bus.in_waddr[c*ADDR_W +: ADDR_W],
                        bus.in_wdata[c*DATA_W +: DATA_W]}),
               .q     (slot_q[s][c])
            );
         end else begin : g_next
            wb_pipe_slot #(.W(SW)) u_slot (
               .clk   (clk),
               .load  (adv),
               .hold  (bus.stall_here),
               .clear (clr_all),
               .d     (slot_q[s-1][c]),
               .q     (slot_q[s][c])
            );
         end
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_out
      assign bus.out_we[c]                   = slot_q[DEPTH-1][c][SW-1];
      assign bus.out_waddr[c*ADDR_W +: ADDR_W] = slot_q[DEPTH-1][c][DATA_W +: ADDR_W];
      assign bus.out_wdata[c*DATA_W +: DATA_W] = slot_q[DEPTH-1][c][DATA_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst == RST_EN)
         bcnt <= '0;
      else if (!bus.flush && bubble && bcnt != '1)
         bcnt <= bcnt + 1'b1;
   end

   assign bus.bubble_cnt = bcnt;

`ifdef WB_HILO_EN
   localparam int unsigned HW = 1 + 2*DATA_W;

   logic [HW-1:0] hilo_q [DEPTH];

   for (genvar s = 0; s < DEPTH; s++) begin : g_hilo
      if (s == 0) begin : g_first
         wb_pipe_slot #(.W(HW)) u_slot (
            .clk   (clk),
            .load  (adv),
            .hold  (bus.stall_here),
            .clear (clr_s0),
            .d     ({bus.in_whilo, bus.in_hi, bus.in_lo}),
            .q     (hilo_q[s])
         );
      end else begin : g_next
         wb_pipe_slot #(.W(HW)) u_slot (
            .clk   (clk),
            .load  (adv),
            .hold  (bus.stall_here),
            .clear (clr_all),
            .d     (hilo_q[s-1]),
            .q     (hilo_q[s])
         );
      end
   end

   assign bus.out_whilo = hilo_q[DEPTH-1][HW-1];
   assign bus.out_hi    = hilo_q[DEPTH-1][DATA_W +: DATA_W];
   assign bus.out_lo    = hilo_q[DEPTH-1][DATA_W-1:0];
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench: table vectors on a DEPTH=1 instance, hand sequences on a
// DEPTH=2/NCH=2/BCNT_W=4 instance.
module tb_wb_pipe_stage;
   import wb_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   wb_if #(.DATA_W(32), .ADDR_W(5), .NCH(2), .BCNT_W(4))  bus_a ();
   wb_if #(.DATA_W(32), .ADDR_W(5), .NCH(1), .BCNT_W(16)) bus_b ();

   wb_pipe_stage #(.DATA_W(32), .ADDR_W(5), .NCH(2), .DEPTH(2), .BCNT_W(4)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   wb_pipe_stage #(.DATA_W(32), .ADDR_W(5), .NCH(1), .DEPTH(1), .BCNT_W(16)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   typedef struct {
      logic        su;
      logic        sh;
      logic        fl;
      wb_slot_t    din;
      wb_slot_t    dexp;
      logic [15:0] bexp;
   } vec_t;

   vec_t vecs [11];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive_a(input logic su, input logic sh, input logic fl, input logic [1:0] we,
                          input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1);
      bus_a.stall_up   = su;
      bus_a.stall_here = sh;
      bus_a.flush      = fl;
      bus_a.in_we      = we;
      bus_a.in_waddr   = {a1, a0};
      bus_a.in_wdata   = {d1, d0};
   endtask

   task automatic check_a(input string name, input logic [1:0] we,
                          input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1,
                          input logic [3:0] bc);
      check({name, ".we"},    64'(bus_a.out_we),     64'(we));
      check({name, ".waddr"}, 64'(bus_a.out_waddr),  64'({a1, a0}));
      check({name, ".wdata"}, bus_a.out_wdata,       {d1, d0});
      check({name, ".bcnt"},  64'(bus_a.bubble_cnt), 64'(bc));
   endtask

   initial begin
      //           su    sh    fl    {we,addr,data in}        {we,addr,data expected}  bcnt
      vecs[0]  = '{1'b0, 1'b0, 1'b0, '{1'b1, 5'd1, 32'h11}, '{1'b1, 5'd1, 32'h11}, 16'd0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, '{1'b1, 5'd2, 32'h22}, '{1'b1, 5'd2, 32'h22}, 16'd0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, '{1'b1, 5'd3, 32'h33}, '{1'b0, 5'd0, 32'h0},  16'd1};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, '{1'b1, 5'd4, 32'h44}, '{1'b0, 5'd0, 32'h0},  16'd1};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, '{1'b1, 5'd4, 32'h44}, '{1'b1, 5'd4, 32'h44}, 16'd1};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, '{1'b1, 5'd5, 32'h55}, '{1'b1, 5'd4, 32'h44}, 16'd1};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, '{1'b1, 5'd6, 32'h66}, '{1'b0, 5'd0, 32'h0},  16'd1};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, '{1'b1, 5'd0, 32'h77}, '{1'b1, 5'd0, 32'h77}, 16'd1};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, '{1'b0, 5'd9, 32'h99}, '{1'b0, 5'd9, 32'h99}, 16'd1};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, '{1'b1, 5'd8, 32'h88}, '{1'b0, 5'd0, 32'h0},  16'd1};
      vecs[10] = '{1'b1, 1'b0, 1'b0, '{1'b0, 5'd0, 32'h0},  '{1'b0, 5'd0, 32'h0},  16'd2};

      rst = 1'b1;
      drive_a(1'b0, 1'b0, 1'b0, 2'b01, 5'd3, 32'hDEAD, 5'd3, 32'hDEAD);
      bus_b.stall_up = 1'b0; bus_b.stall_here = 1'b0; bus_b.flush = 1'b0;
      bus_b.in_we = 1'b1; bus_b.in_waddr = 5'd3; bus_b.in_wdata = 32'hDEAD;
      step();
      step();
      check_a("reset_a", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 4'd0);
      check("reset_b.we",    64'(bus_b.out_we),     64'd0);
      check("reset_b.waddr", 64'(bus_b.out_waddr),  64'd0);
      check("reset_b.wdata", 64'(bus_b.out_wdata),  64'd0);
      check("reset_b.bcnt",  64'(bus_b.bubble_cnt), 64'd0);
      rst = 1'b0;
      drive_a(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

      // Table on the DEPTH=1 instance: outputs reflect the row on the next edge.
      for (int i = 0; i < 11; i++) begin
         bus_b.stall_up   = vecs[i].su;
         bus_b.stall_here = vecs[i].sh;
         bus_b.flush      = vecs[i].fl;
         bus_b.in_we      = vecs[i].din.we;
         bus_b.in_waddr   = vecs[i].din.waddr;
         bus_b.in_wdata   = vecs[i].din.wdata;
         step();
         check($sformatf("vec%0d.we", i),    64'(bus_b.out_we),     64'(vecs[i].dexp.we));
         check($sformatf("vec%0d.waddr", i), 64'(bus_b.out_waddr),  64'(vecs[i].dexp.waddr));
         check($sformatf("vec%0d.wdata", i), 64'(bus_b.out_wdata),  64'(vecs[i].dexp.wdata));
         check($sformatf("vec%0d.bcnt", i),  64'(bus_b.bubble_cnt), 64'(vecs[i].bexp));
      end
      bus_b.stall_up = 1'b0; bus_b.stall_here = 1'b0; bus_b.flush = 1'b0;
      bus_b.in_we = 1'b0; bus_b.in_waddr = '0; bus_b.in_wdata = '0;

      // Passthrough, two-cycle latency on channel 0.
      for (int k = 0; k < 6; k++) begin
         if (k < 4)
            drive_a(1'b0, 1'b0, 1'b0, 2'b01, 5'(k + 1), 32'(32'h11 * (k + 1)), 5'd0, 32'h0);
         else
            drive_a(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
         step();
         if (k >= 1 && k <= 4)
            check_a($sformatf("pass%0d", k), 2'b01, 5'(k), 32'(32'h11 * k), 5'd0, 32'h0, 4'd0);
         else
            check_a($sformatf("pass%0d", k), 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 4'd0);
      end

      // Bubble insertion, then hold with both stalls.
      drive_a(1'b0, 1'b0, 1'b0, 2'b01, 5'd6, 32'h66, 5'd0, 32'h0); step();
      drive_a(1'b0, 1'b0, 1'b0, 2'b01, 5'd7, 32'h77, 5'd0, 32'h0); step();
      check_a("pre_stall", 2'b01, 5'd6, 32'h66, 5'd0, 32'h0, 4'd0);
      drive_a(1'b1, 1'b0, 1'b0, 2'b01, 5'd9, 32'h99, 5'd0, 32'h0); step();
      check_a("stall1", 2'b01, 5'd7, 32'h77, 5'd0, 32'h0, 4'd1);
      step();
      check_a("stall2", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 4'd2);
      step();
      check_a("stall3", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 4'd3);
      drive_a(1'b0, 1'b0, 1'b0, 2'b01, 5'd10, 32'hAA, 5'd0, 32'h0); step();
      check_a("post_bubble", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 4'd3);
      drive_a(1'b0, 1'b0, 1'b0, 2'b01, 5'd11, 32'hBB, 5'd0, 32'h0); step();
      check_a("refill", 2'b01, 5'd10, 32'hAA, 5'd0, 32'h0, 4'd3);
      drive_a(1'b1, 1'b1, 1'b0, 2'b01, 5'd9, 32'h99, 5'd0, 32'h0); step();
      check_a("hold1", 2'b01, 5'd10, 32'hAA, 5'd0, 32'h0, 4'd3);
      step();
      check_a("hold2", 2'b01, 5'd10, 32'hAA, 5'd0, 32'h0, 4'd3);
      drive_a(1'b0, 1'b0, 1'b0, 2'b01, 5'd7, 32'h77, 5'd0, 32'h0); step();
      check_a("release", 2'b01, 5'd11, 32'hBB, 5'd0, 32'h0, 4'd3);
      step();
      check_a("fill7", 2'b01, 5'd7, 32'h77, 5'd0, 32'h0, 4'd3);

      // Flush beats hold; both stages are empty afterwards.
      drive_a(1'b0, 1'b1, 1'b1, 2'b01, 5'd9, 32'h99, 5'd0, 32'h0); step();
      check_a("flush", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 4'd3);
      drive_a(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0); step();
      check_a("flush_s0", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 4'd3);

      // Same-beat conflict resolution.
      drive_a(1'b0, 1'b0, 1'b0, 2'b11, 5'd5, 32'hA, 5'd5, 32'hB); step();
      drive_a(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0); step();
      check_a("conflict", 2'b10, 5'd5, 32'hA, 5'd5, 32'hB, 4'd3);
      drive_a(1'b0, 1'b0, 1'b0, 2'b11, 5'd3, 32'hC, 5'd4, 32'hD); step();
      drive_a(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0); step();
      check_a("no_conflict", 2'b11, 5'd3, 32'hC, 5'd4, 32'hD, 4'd3);
      drive_a(1'b0, 1'b0, 1'b0, 2'b01, 5'd5, 32'hE, 5'd5, 32'hF); step();
      drive_a(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0); step();
      check_a("one_we_same_addr", 2'b01, 5'd5, 32'hE, 5'd5, 32'hF, 4'd3);

      // Saturation of the 4-bit bubble counter.
      drive_a(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      for (int k = 0; k < 20; k++) step();
      check("sat.bcnt", 64'(bus_a.bubble_cnt), 64'd15);
      step();
      check("sat_hold.bcnt", 64'(bus_a.bubble_cnt), 64'd15);

      // Reset mid-stream overrides stall and flush.
      drive_a(1'b0, 1'b0, 1'b0, 2'b01, 5'd1, 32'h11, 5'd0, 32'h0); step();
      drive_a(1'b0, 1'b0, 1'b0, 2'b01, 5'd2, 32'h22, 5'd0, 32'h0); step();
      check_a("pre_rst", 2'b01, 5'd1, 32'h11, 5'd0, 32'h0, 4'd15);
      rst = 1'b1;
      drive_a(1'b1, 1'b1, 1'b1, 2'b01, 5'd3, 32'h33, 5'd0, 32'h0); step();
      check_a("mid_rst", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 4'd0);
      rst = 1'b0;
      drive_a(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0); step();
      check_a("post_rst", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
